muldiv_seq: RTL

Iterative multiply/divide sequencer for the CPU54 single-cycle core. It executes MULT, MULTU, DIV and DIVU one bit per cycle and owns the architectural HI/LO registers. It asserts busy so the core's control unit stalls PC and register-file writeback until the result is committed. It also services MTHI/MTLO writes; MFHI/MFLO read the hi/lo outputs directly.

---
 rtl/muldiv_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO. Computes one bit per
// cycle on magnitudes, then fixes signs in a single SIGN cycle before committing.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_raw_rs;
  logic [WIDTH-1:0]   r_b;      // divisor magnitude (also tested for zero)
  logic [WIDTH-1:0]   r_x;      // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [2*WIDTH-1:0] r_y;      // multiplicand, shifted left each step
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  logic [WIDTH-1:0]   w_abs_rs;
  logic [WIDTH-1:0]   w_abs_rt;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic               w_dz;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_SIGN;
      S_SIGN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_abs_rs = (op[0] && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign w_abs_rt = (op[0] && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // Restoring step; a set top bit in the shifted remainder already exceeds any divisor.
  assign w_shift = {r_rem, r_x[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_b};
  assign w_ge    = w_shift[WIDTH] | ~w_trial[WIDTH];

  assign w_dz   = (r_b == '0);
  assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
  assign w_quo  = (r_sign_a ^ r_sign_b) ? -r_x : r_x;
  assign w_rem  = r_sign_a ? -r_rem : r_rem;

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_op[1]) begin
      if (w_dz) begin
        w_res_hi = r_raw_rs;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_raw_rs   <= '0;
      r_b        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_sign_a <= op[0] & rs_val[WIDTH-1];
            r_sign_b <= op[0] & rt_val[WIDTH-1];
            r_raw_rs <= rs_val;
            r_b      <= w_abs_rt;
            r_x      <= op[1] ? w_abs_rs : w_abs_rt;
            r_y      <= {{WIDTH{1'b0}}, w_abs_rs};
            r_acc    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_op[1]) begin
            r_rem <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_x   <= {r_x[WIDTH-2:0], w_ge};
          end else begin
            if (r_x[0]) r_acc <= r_acc + r_y;
            r_y <= r_y << 1;
            r_x <= r_x >> 1;
          end
        end
        S_SIGN: begin
          r_hi       <= w_res_hi;
          r_lo       <= w_res_lo;
          r_done     <= 1'b1;
          r_div_zero <= r_op[1] & w_dz;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
